// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_pkg
//  Description : Shared ROM geometry, arbiter priority states and response type.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_pkg;

    localparam int ROM_SIZE = 160;
    localparam int WORD_W   = 32;

    typedef enum logic [0:0] {
        PRI_DATA  = 1'b0,
        PRI_FETCH = 1'b1
    } pri_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              err;
    } rom_rsp_t;

endpackage
`default_nettype wire

// File: rtl/rom_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_buf
//  Description : One-entry fetch word buffer with word-index hit compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_buf #(
    parameter int IDX_W  = 29,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_idx   <= load_idx;
            r_data  <= load_data;
        end
    end

    assign hit      = r_valid && (r_idx == lookup_idx);
    assign hit_data = r_data;

endmodule
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_port_arbiter
//  Description : Shares the ROM read port between instruction fetch and data
//                loads, with starvation-bounded fetch priority and a fetch buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter
    import rom_pkg::*;
#(
    parameter int ADDR_W       = 31,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rerr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rerr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_overflow
);

    localparam int                c_idx_w   = ADDR_W - 2;
    localparam int                c_cnt_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve = c_cnt_w'(STARVE_LIMIT);

    pri_state_t         r_state, w_state_next;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic [ADDR_W-1:0]  r_rom_addr;
    rom_rsp_t           r_f_rsp, r_d_rsp;

    logic               w_f_rom, w_d_rom, w_f_from_buf;
    logic               w_buf_hit;
    logic [DATA_W-1:0]  w_buf_data;

    rom_fetch_buf #(
        .IDX_W  (c_idx_w),
        .DATA_W (DATA_W)
    ) u_fetch_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_f_rom && !rom_overflow),
        .load_idx   (f_addr[ADDR_W-1:2]),
        .load_data  (rom_data),
        .lookup_idx (f_addr[ADDR_W-1:2]),
        .hit        (w_buf_hit),
        .hit_data   (w_buf_data)
    );

    // Grants are held low while reset is asserted.
    always_comb begin
        w_f_rom      = 1'b0;
        w_d_rom      = 1'b0;
        w_f_from_buf = 1'b0;
        if (reset_n) begin
            if (f_req && d_req) begin
                if (w_buf_hit) begin
                    w_d_rom      = 1'b1;
                    w_f_from_buf = 1'b1;
                end else if (r_state == PRI_FETCH) begin
                    w_f_rom = 1'b1;
                end else begin
                    w_d_rom = 1'b1;
                end
            end else if (f_req) begin
                w_f_rom = 1'b1;
            end else if (d_req) begin
                w_d_rom = 1'b1;
            end
        end
    end

    assign f_gnt    = w_f_rom | w_f_from_buf;
    assign d_gnt    = w_d_rom;
    assign rom_addr = w_f_rom ? f_addr : (w_d_rom ? d_addr : r_rom_addr);

    // Counter saturates at the limit; a buffer-hit grant clears it but leaves the FSM alone.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        if (f_gnt) begin
            w_cnt_next = '0;
        end else if (f_req && (r_cnt != c_starve)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
        if (w_f_rom) begin
            w_state_next = PRI_DATA;
        end else if (w_cnt_next == c_starve) begin
            w_state_next = PRI_FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= PRI_DATA;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_f_rsp    <= '0;
            r_d_rsp    <= '0;
        end else begin
            r_rom_addr    <= rom_addr;
            r_f_rsp.valid <= f_gnt;
            r_d_rsp.valid <= d_gnt;
            if (w_f_from_buf) begin
                r_f_rsp.data <= w_buf_data;
                r_f_rsp.err  <= 1'b0;
            end else if (w_f_rom) begin
                r_f_rsp.data <= rom_overflow ? '0 : rom_data;
                r_f_rsp.err  <= rom_overflow;
            end
            if (w_d_rom) begin
                r_d_rsp.data <= rom_overflow ? '0 : rom_data;
                r_d_rsp.err  <= rom_overflow;
            end
        end
    end

    assign f_rvalid = r_f_rsp.valid;
    assign f_rdata  = r_f_rsp.data;
    assign f_rerr   = r_f_rsp.err;
    assign d_rvalid = r_d_rsp.valid;
    assign d_rdata  = r_d_rsp.data;
    assign d_rerr   = r_d_rsp.err;

endmodule
`default_nettype wire
